// File: rtl/z16_pkg.sv
// z16_pkg: shared Z16 widths, PC step and fetch FSM state encodings
package z16_pkg;
   localparam int Z16_INSTR_W = 16;
   localparam logic [15:0] Z16_PC_STEP = 16'd2;
   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_FETCH = 2'b01,
      ST_HALT  = 2'b10,
      ST_FAULT = 2'b11
   } fetch_state_e;
endpackage

// File: rtl/z16_pc_next.sv
// z16_pc_next: combinational next-PC select with misalign and range fault flags
module z16_pc_next import z16_pkg::*; #(
   parameter int IMEM_WORDS = 11
) (
   input  logic [15:0] i_pc,
   input  logic        i_redirect,
   input  logic [15:0] i_target,
   input  logic        i_load,
   output logic [15:0] o_pc_next,
   output logic        o_misalign,
   output logic        o_range
);
   assign o_pc_next  = i_redirect ? i_target : i_load ? i_pc + Z16_PC_STEP : i_pc;
   assign o_misalign = i_redirect & i_target[0];
   assign o_range    = i_load & ({17'b0, i_pc[15:1]} >= IMEM_WORDS);
endmodule

// File: rtl/z16_fetch_ctrl.sv
// z16_fetch_ctrl: PC sequencer with one-entry valid/ready instruction buffer
module z16_fetch_ctrl import z16_pkg::*; #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter int IMEM_WORDS = 11
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_run,
   input  logic                   i_halt,
   input  logic                   i_redirect,
   input  logic [15:0]            i_redirect_pc,
   output logic [15:0]            o_imem_addr,
   input  logic [Z16_INSTR_W-1:0] i_imem_instr,
   output logic [Z16_INSTR_W-1:0] o_instr,
   output logic [15:0]            o_instr_pc,
   output logic                   o_valid,
   input  logic                   i_ready,
   output logic [1:0]             o_state,
   output logic                   o_fault
);
   fetch_state_e state_q, state_d;
   logic [15:0] pc_q, pc_d, pc_nxt, instr_pc_q, instr_pc_d;
   logic [Z16_INSTR_W-1:0] instr_q, instr_d;
   logic valid_q, valid_d, fault_q, fault_d;
   logic free, load_req, misalign, range_err;

   assign free     = !valid_q | i_ready;
   assign load_req = (state_q == ST_FETCH) & i_run & free & !i_halt & !i_redirect;

   z16_pc_next #(.IMEM_WORDS(IMEM_WORDS)) u_pc_next (
      .i_pc       (pc_q),
      .i_redirect (i_redirect),
      .i_target   (i_redirect_pc),
      .i_load     (load_req),
      .o_pc_next  (pc_nxt),
      .o_misalign (misalign),
      .o_range    (range_err)
   );

   // next state: halt beats redirect beats faults beats load/accept; HALT/FAULT only drain
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      instr_d    = instr_q;
      instr_pc_d = instr_pc_q;
      fault_d    = fault_q;
      valid_d    = valid_q & !i_ready;
      if (state_q == ST_IDLE || state_q == ST_FETCH) begin
         if (i_halt) begin
            state_d = ST_HALT;
            valid_d = 1'b0;
         end else if (misalign | range_err) begin
            state_d = ST_FAULT;
            fault_d = 1'b1;
            valid_d = 1'b0;
         end else begin
            pc_d    = pc_nxt;
            state_d = i_run ? ST_FETCH : ST_IDLE;
            if (load_req) begin
               instr_d    = i_imem_instr;
               instr_pc_d = pc_q;
               valid_d    = 1'b1;
            end
            if (i_redirect) valid_d = 1'b0;
         end
      end
   end

   // state register, async clear of everything including the buffer
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= ST_IDLE;
         pc_q       <= RESET_PC;
         instr_q    <= '0;
         instr_pc_q <= 16'h0000;
         valid_q    <= 1'b0;
         fault_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         instr_q    <= instr_d;
         instr_pc_q <= instr_pc_d;
         valid_q    <= valid_d;
         fault_q    <= fault_d;
      end
   end

   assign o_imem_addr = pc_q;
   assign o_instr     = instr_q;
   assign o_instr_pc  = instr_pc_q;
   assign o_valid     = valid_q;
   assign o_state     = state_q;
   assign o_fault     = fault_q;
endmodule

// File: tb/tb_z16_fetch_ctrl.sv
// tb_z16_fetch_ctrl: directed bench for fetch sequencing, stall, redirect, faults, halt, reset
module tb_z16_fetch_ctrl;
   logic i_clk = 1'b0, i_rst_n = 1'b0;
   logic i_run = 1'b0, i_halt = 1'b0, i_redirect = 1'b0, i_ready = 1'b0;
   logic [15:0] i_redirect_pc = 16'h0000;
   logic [15:0] a_addr, a_imem, a_instr, a_ipc, b_addr, b_imem, b_instr, b_ipc;
   logic a_valid, a_fault, b_valid, b_fault;
   logic [1:0] a_state, b_state;
   logic [15:0] mem [16];
   int checks = 0, passed = 0;

   always #5 i_clk = ~i_clk;

   assign a_imem = (a_addr[15:5] == 11'd0) ? mem[a_addr[4:1]] : 16'h0000;
   assign b_imem = (b_addr[15:5] == 11'd0) ? mem[b_addr[4:1]] : 16'h0000;

   z16_fetch_ctrl #(.RESET_PC(16'h0000), .IMEM_WORDS(11)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_run(i_run), .i_halt(i_halt),
      .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc), .o_imem_addr(a_addr),
      .i_imem_instr(a_imem), .o_instr(a_instr), .o_instr_pc(a_ipc), .o_valid(a_valid),
      .i_ready(i_ready), .o_state(a_state), .o_fault(a_fault)
   );

   z16_fetch_ctrl #(.RESET_PC(16'h0000), .IMEM_WORDS(12)) dut12 (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_run(i_run), .i_halt(i_halt),
      .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc), .o_imem_addr(b_addr),
      .i_imem_instr(b_imem), .o_instr(b_instr), .o_instr_pc(b_ipc), .o_valid(b_valid),
      .i_ready(i_ready), .o_state(b_state), .o_fault(b_fault)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic do_reset();
      i_rst_n = 1'b0;
      i_run = 1'b0; i_halt = 1'b0; i_redirect = 1'b0; i_ready = 1'b0;
      tick();
      tick();
      i_rst_n = 1'b1;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_state"}, {14'b0, a_state}, 16'h0000);
      chk({tag, "_valid"}, {15'b0, a_valid}, 16'h0000);
      chk({tag, "_instr"}, a_instr, 16'h0000);
      chk({tag, "_ipc"}, a_ipc, 16'h0000);
      chk({tag, "_addr"}, a_addr, 16'h0000);
      chk({tag, "_fault"}, {15'b0, a_fault}, 16'h0000);
   endtask

   initial begin
      foreach (mem[i]) mem[i] = 16'h0000;
      mem[0] = 16'h0010; mem[1] = 16'h0020; mem[2] = 16'h0A19; mem[3] = 16'h1220;
      mem[4] = 16'hFF19; mem[5] = 16'hFC4F; mem[6] = 16'h00FD; mem[7] = 16'h0707;
      mem[8] = 16'h0808; mem[9] = 16'h0909; mem[10] = 16'h0A0A; mem[11] = 16'h0B0B;
      mem[12] = 16'h0C0C;
      do_reset();
      chk_reset("rst");
      i_run = 1'b1; i_ready = 1'b1;
      tick();
      chk("idle_to_fetch", {14'b0, a_state}, 16'h0001);
      chk("first_not_valid", {15'b0, a_valid}, 16'h0000);
      tick();
      chk("i0_instr", a_instr, 16'h0010);
      chk("i0_pc", a_ipc, 16'h0000);
      chk("i0_valid", {15'b0, a_valid}, 16'h0001);
      chk("i0_addr", a_addr, 16'h0002);
      tick();
      chk("i1_instr", a_instr, 16'h0020);
      chk("i1_pc", a_ipc, 16'h0002);
      chk("i1_addr", a_addr, 16'h0004);
      tick();
      chk("i2_instr", a_instr, 16'h0A19);
      chk("i2_pc", a_ipc, 16'h0004);
      chk("i2_addr", a_addr, 16'h0006);
      tick();
      chk("i3_instr", a_instr, 16'h1220);
      chk("i3_pc", a_ipc, 16'h0006);
      i_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("stall_instr", a_instr, 16'h1220);
         chk("stall_pc", a_ipc, 16'h0006);
         chk("stall_valid", {15'b0, a_valid}, 16'h0001);
         chk("stall_addr", a_addr, 16'h0008);
      end
      i_ready = 1'b1;
      tick();
      chk("resume_instr", a_instr, 16'hFF19);
      chk("resume_pc", a_ipc, 16'h0008);
      tick();
      chk("i5_instr", a_instr, 16'hFC4F);
      chk("i5_pc", a_ipc, 16'h000A);
      i_redirect = 1'b1; i_redirect_pc = 16'h0006;
      tick();
      i_redirect = 1'b0;
      chk("redir_bubble", {15'b0, a_valid}, 16'h0000);
      chk("redir_addr", a_addr, 16'h0006);
      tick();
      chk("redir_instr", a_instr, 16'h1220);
      chk("redir_pc", a_ipc, 16'h0006);
      chk("redir_valid", {15'b0, a_valid}, 16'h0001);
      i_redirect = 1'b1; i_redirect_pc = 16'h0005;
      tick();
      i_redirect = 1'b0;
      chk("mis_state", {14'b0, a_state}, 16'h0003);
      chk("mis_fault", {15'b0, a_fault}, 16'h0001);
      chk("mis_valid", {15'b0, a_valid}, 16'h0000);
      tick();
      tick();
      chk("mis_sticky", {14'b0, a_state}, 16'h0003);
      #2;
      i_rst_n = 1'b0;
      #1;
      chk_reset("async_from_fault");
      do_reset();
      i_run = 1'b1; i_ready = 1'b1;
      tick();
      repeat (11) tick();
      chk("w10_instr", a_instr, 16'h0A0A);
      chk("w10_pc", a_ipc, 16'h0014);
      chk("w10_addr", a_addr, 16'h0016);
      tick();
      chk("range_state", {14'b0, a_state}, 16'h0003);
      chk("range_fault", {15'b0, a_fault}, 16'h0001);
      chk("range_valid", {15'b0, a_valid}, 16'h0000);
      chk("w12_instr", b_instr, 16'h0B0B);
      chk("w12_pc", b_ipc, 16'h0016);
      chk("w12_valid", {15'b0, b_valid}, 16'h0001);
      tick();
      chk("w12_range_state", {14'b0, b_state}, 16'h0003);
      do_reset();
      i_run = 1'b1; i_ready = 1'b1;
      tick();
      tick();
      chk("pre_halt_valid", {15'b0, a_valid}, 16'h0001);
      i_halt = 1'b1;
      tick();
      i_halt = 1'b0;
      chk("halt_state", {14'b0, a_state}, 16'h0002);
      chk("halt_valid", {15'b0, a_valid}, 16'h0000);
      chk("halt_addr", a_addr, 16'h0002);
      i_redirect = 1'b1; i_redirect_pc = 16'h0008;
      tick();
      i_redirect = 1'b0;
      chk("halt_redir_addr", a_addr, 16'h0002);
      chk("halt_redir_state", {14'b0, a_state}, 16'h0002);
      do_reset();
      i_run = 1'b1; i_ready = 1'b1;
      tick();
      tick();
      tick();
      chk("mid_instr", a_instr, 16'h0020);
      i_ready = 1'b0;
      #3;
      i_rst_n = 1'b0;
      #1;
      chk_reset("async_mid");
      #2;
      i_rst_n = 1'b1;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

// File: doc/z16_fetch_ctrl.md
# z16_fetch_ctrl

Instruction-fetch sequencer for the Z16 core. Owns the program counter, drives the byte address into the combinational instruction memory, and presents each fetched 16-bit instruction with its PC to decode through a single-entry valid/ready buffer. It also accepts branch/jump redirects from execute, and stops on halt or on a fetch fault.

## Interface
Parameters:
- RESET_PC, 16'h0000, byte address of the first fetch after reset (must be even)
- IMEM_WORDS, 11, number of implemented instruction words; a word index ≥ IMEM_WORDS is out of range

Ports:
- i_clk  in  1  single clock, all state on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_run  in  1  level; 1 = fetching permitted
- i_halt  in  1  pulse from execute; stop fetching permanently
- i_redirect  in  1  pulse; load new PC (branch taken / JRL)
- i_redirect_pc  in  16  redirect target byte address
- o_imem_addr  out  16  byte address to instruction memory; word index = bits [15:1]
- i_imem_instr  in  16  instruction read combinationally at o_imem_addr
- o_instr  out  16  buffered instruction
- o_instr_pc  out  16  byte address of o_instr
- o_valid  out  1  o_instr/o_instr_pc valid
- i_ready  in  1  decode accepts when o_valid & i_ready
- o_state  out  2  FSM state encoding
- o_fault  out  1  sticky fetch fault

## Operation
- State encodings:
  - IDLE = 2'b00: no loads; held buffer may still be accepted.
  - FETCH = 2'b01.
  - HALT = 2'b10: sticky until reset.
  - FAULT = 2'b11: sticky until reset.
- State transitions:
  - IDLE → FETCH when i_run=1.
  - FETCH → IDLE when i_run=0; pc and buffer are kept.
  - FETCH/IDLE → HALT on i_halt.
  - FETCH → FAULT on a fault condition.
- o_imem_addr = pc register, combinational.
- Load (FETCH only): when the buffer is free (o_valid=0, or o_valid & i_ready), and there is no redirect or halt this cycle:
  - o_instr ← i_imem_instr
  - o_instr_pc ← pc
  - o_valid ← 1
  - pc ← pc + 2, modulo 2^16
- Accept without load: o_valid ← 0.
- Stall: o_valid & !i_ready keeps the buffer and pc unchanged.
- Redirect (highest priority after halt, any state except HALT/FAULT):
  - pc ← i_redirect_pc, o_valid ← 0; no load that cycle.
  - A same-cycle handshake still counts as accepted.
- Faults (enter FAULT, o_fault ← 1, o_valid ← 0):
  - i_redirect with i_redirect_pc[0]=1
  - a load attempted with pc[15:1] ≥ IMEM_WORDS
- Halt: o_valid ← 0, pc retained; redirects are ignored in HALT.
- Priority: reset > i_halt > i_redirect > fault check > load/accept.

## Timing
- Reset (async assert, sync release):
  - pc = RESET_PC
  - o_instr = 16'h0000
  - o_instr_pc = 16'h0000
  - o_valid = 0
  - o_state = IDLE
  - o_fault = 0
- Latency: i_run rises at cycle N → state FETCH at N+1 → o_valid=1 with the instruction at RESET_PC at N+2.
- Throughput: one instruction per cycle while i_ready=1.
- Redirect at cycle N → o_valid=0 at N+1, target instruction valid at N+2 (one bubble).
- pc wrap at 16'hFFFE → 16'h0000 is arithmetic only; range check still applies.
- Reset mid-stall or mid-redirect: all state is discarded immediately, buffer cleared.

## Structure
- Shared package z16_pkg:
  - Fetch FSM state localparams (IDLE/FETCH/HALT/FAULT)
  - Z16_INSTR_W = 16
  - Z16_PC_STEP = 2
- One natural sub-module: z16_pc_next, combinational next-PC and fault mux (inputs pc, redirect, target, load enable; outputs next pc, misalign flag, range flag).
- The FSM and the one-entry buffer stay in the top module.

## Test plan
Bench memory image: word 0 = 16'h0010, word 1 = 16'h0020, word 2 = 16'h0A19, word 3 = 16'h1220, word 4 = 16'hFF19, word 5 = 16'hFC4F, word 6 = 16'h00FD.
- Reset, i_run=1, i_ready=1 → o_instr 16'h0010 @pc 0, 16'h0020 @2, 16'h0A19 @4 on consecutive cycles; o_imem_addr 0, 2, 4, 6.
- i_ready=0 for 3 cycles while holding 16'h1220 @6 → o_instr/o_instr_pc stable; o_imem_addr stays 16'h0008; resumes with 16'hFF19 @8.
- i_redirect, i_redirect_pc=16'h0006, while 16'hFC4F @10 is accepted → one cycle o_valid=0, then 16'h1220 @6.
- i_redirect_pc=16'h0005 → o_state=2'b11, o_fault=1, o_valid=0; stays until i_rst_n low.
- Sequential fetch to pc=16'h0016 (word 11) → FAULT; with IMEM_WORDS=12 the fetch completes instead.
- i_halt while o_valid=1 → o_state=2'b10, o_valid=0; a later i_redirect is ignored; async reset mid-stream → all outputs at reset values within the same cycle.
